// File: rtl/mpf_rd_stream_engine.sv
// Read-streaming engine: fetches a run of cache lines on the MPF c0 channel in
// 1/2/4-line bursts, credit-limited by line-buffer occupancy, with optional throttle.
module mpf_rd_stream_engine #(
    parameter int unsigned BUF_DEPTH  = 64,
    parameter int unsigned MAX_CL_LEN = 4,
    parameter int unsigned LEN_W      = 32,
    parameter int unsigned CNT_W      = $clog2(BUF_DEPTH) + 1,
    parameter int unsigned CL_ADDR_W  = 42
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CL_ADDR_W-1:0] base_cl_addr_i,
    input  logic [LEN_W-1:0]     num_lines_i,
    input  logic [7:0]           throttle_i,
    output logic                 c0_tx_valid_o,
    output logic [CL_ADDR_W-1:0] c0_tx_addr_o,
    output logic [1:0]           c0_tx_cl_len_o,
    output logic [3:0]           c0_tx_req_type_o,
    output logic [1:0]           c0_tx_vc_sel_o,
    output logic [15:0]          c0_tx_mdata_o,
    output logic                 c0_tx_addr_is_virtual_o,
    input  logic                 c0_tx_alm_full_i,
    input  logic                 c0_rx_rsp_valid_i,
    input  logic [3:0]           c0_rx_resp_type_i,
    input  logic [511:0]         c0_rx_data_i,
    output logic                 buf_wr_en_o,
    output logic [511:0]         buf_wr_data_o,
    input  logic                 buf_pop_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o
);

    localparam logic [3:0] REQ_RDLINE_I = 4'h0;
    localparam logic [3:0] RSP_RDLINE   = 4'h0;
    localparam logic [1:0] VC_VA        = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CL_ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [LEN_W-1:0]     num_lines_q, num_lines_d;
    logic [LEN_W-1:0]     issued_q, issued_d;
    logic [LEN_W-1:0]     received_q, received_d;
    logic [7:0]           throttle_q, throttle_d;
    logic [7:0]           thr_cnt_q, thr_cnt_d;
    logic [CNT_W-1:0]     occ_q, occ_d;
    logic [CNT_W-1:0]     out_q, out_d;
    logic                 abort_seen_q, abort_seen_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [CL_ADDR_W-1:0] tx_addr_q, tx_addr_d;
    logic [1:0]           tx_cl_len_q, tx_cl_len_d;
    logic                 wr_en_q, wr_en_d;
    logic [511:0]         wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;

    logic [LEN_W-1:0] remaining;
    logic [2:0]       burst_lines;
    logic [CNT_W-1:0] credit_used;
    logic [CNT_W-1:0] credit_free;
    logic             rd_rsp;
    logic             count_rsp;
    logic             pop_ok;
    logic             issue;

    // Burst sizing, credit check and issue qualification
    always_comb begin
        remaining   = num_lines_q - issued_q;
        burst_lines = 3'd1;
        if (MAX_CL_LEN >= 4 && next_addr_q[1:0] == 2'b00 && remaining >= LEN_W'(4)) begin
            burst_lines = 3'd4;
        end else if (MAX_CL_LEN >= 2 && next_addr_q[0] == 1'b0 && remaining >= LEN_W'(2)) begin
            burst_lines = 3'd2;
        end
        credit_used = occ_q + out_q;
        credit_free = CNT_W'(BUF_DEPTH) - credit_used;
        rd_rsp      = c0_rx_rsp_valid_i && (c0_rx_resp_type_i == RSP_RDLINE);
        // Responses arriving outside a run (e.g. after a reset) are written but not counted
        count_rsp   = rd_rsp && (state_q == ST_RUN || state_q == ST_DRAIN);
        pop_ok      = buf_pop_i && (occ_q != '0);
        issue       = (state_q == ST_RUN) && !abort_i && !c0_tx_alm_full_i &&
                      (remaining != '0) && (credit_free >= CNT_W'(burst_lines)) &&
                      (thr_cnt_q == 8'd0);
    end

    // Next-state, counters and registered outputs
    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        num_lines_d  = num_lines_q;
        issued_d     = issued_q;
        received_d   = received_q;
        throttle_d   = throttle_q;
        thr_cnt_d    = thr_cnt_q;
        occ_d        = occ_q;
        out_d        = out_q;
        abort_seen_d = abort_seen_q;
        tx_valid_d   = 1'b0;
        tx_addr_d    = tx_addr_q;
        tx_cl_len_d  = tx_cl_len_q;
        wr_en_d      = rd_rsp;
        wr_data_d    = rd_rsp ? c0_rx_data_i : wr_data_q;

        if (issue) begin
            tx_valid_d  = 1'b1;
            tx_addr_d   = next_addr_q;
            tx_cl_len_d = 2'(burst_lines - 3'd1);
            next_addr_d = next_addr_q + CL_ADDR_W'(burst_lines);
            issued_d    = issued_q + LEN_W'(burst_lines);
            thr_cnt_d   = throttle_q;
        end else if (thr_cnt_q != 8'd0) begin
            thr_cnt_d = thr_cnt_q - 8'd1;
        end

        if (count_rsp) begin
            received_d = received_q + LEN_W'(1);
        end

        out_d = out_q + (issue ? CNT_W'(burst_lines) : '0) - (count_rsp ? CNT_W'(1) : '0);

        case ({count_rsp, pop_ok})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d      = ST_RUN;
                    next_addr_d  = base_cl_addr_i;
                    num_lines_d  = num_lines_i;
                    throttle_d   = throttle_i;
                    issued_d     = '0;
                    received_d   = '0;
                    thr_cnt_d    = 8'd0;
                    abort_seen_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (num_lines_q == '0) begin
                    state_d = ST_DONE;
                end else if (abort_i) begin
                    state_d      = ST_DRAIN;
                    abort_seen_d = 1'b1;
                end else if (issued_q == num_lines_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (received_q == issued_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d    = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d    = (state_d == ST_DONE);
        aborted_d = (state_d == ST_DONE) && abort_seen_d;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            next_addr_q  <= '0;
            num_lines_q  <= '0;
            issued_q     <= '0;
            received_q   <= '0;
            throttle_q   <= 8'd0;
            thr_cnt_q    <= 8'd0;
            occ_q        <= '0;
            out_q        <= '0;
            abort_seen_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_addr_q    <= '0;
            tx_cl_len_q  <= 2'b00;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            num_lines_q  <= num_lines_d;
            issued_q     <= issued_d;
            received_q   <= received_d;
            throttle_q   <= throttle_d;
            thr_cnt_q    <= thr_cnt_d;
            occ_q        <= occ_d;
            out_q        <= out_d;
            abort_seen_q <= abort_seen_d;
            tx_valid_q   <= tx_valid_d;
            tx_addr_q    <= tx_addr_d;
            tx_cl_len_q  <= tx_cl_len_d;
            wr_en_q      <= wr_en_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign c0_tx_valid_o           = tx_valid_q;
    assign c0_tx_addr_o            = tx_addr_q;
    assign c0_tx_cl_len_o          = tx_cl_len_q;
    assign c0_tx_req_type_o        = REQ_RDLINE_I;
    assign c0_tx_vc_sel_o          = VC_VA;
    assign c0_tx_mdata_o           = 16'h0000;
    assign c0_tx_addr_is_virtual_o = 1'b1;
    assign buf_wr_en_o             = wr_en_q;
    assign buf_wr_data_o           = wr_data_q;
    assign busy_o                  = busy_q;
    assign done_o                  = done_q;
    assign aborted_o               = aborted_q;

endmodule

// File: tb/tb_mpf_rd_stream_engine.sv
// Randomised bench for mpf_rd_stream_engine: in-order memory responder, buffer
// consumer and a burst-plan reference model derived from the address/length rules.
module tb_mpf_rd_stream_engine;

    localparam int unsigned BUF_DEPTH = 8;
    localparam int unsigned LEN_W     = 32;
    localparam int unsigned AW        = 42;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [AW-1:0]  base_addr = '0;
    logic [LEN_W-1:0] num_lines = '0;
    logic [7:0]     throttle = 8'd0;
    logic           tx_valid;
    logic [AW-1:0]  tx_addr;
    logic [1:0]     tx_cl_len;
    logic [3:0]     tx_req_type;
    logic [1:0]     tx_vc_sel;
    logic [15:0]    tx_mdata;
    logic           tx_va;
    logic           alm_full = 1'b0;
    logic           rx_valid = 1'b0;
    logic [3:0]     rx_type = 4'h0;
    logic [511:0]   rx_data = '0;
    logic           wr_en;
    logic [511:0]   wr_data;
    logic           buf_pop = 1'b0;
    logic           busy, done, aborted;

    always #5 clk = ~clk;

    mpf_rd_stream_engine #(.BUF_DEPTH(BUF_DEPTH), .MAX_CL_LEN(4), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .base_cl_addr_i(base_addr), .num_lines_i(num_lines), .throttle_i(throttle),
        .c0_tx_valid_o(tx_valid), .c0_tx_addr_o(tx_addr), .c0_tx_cl_len_o(tx_cl_len),
        .c0_tx_req_type_o(tx_req_type), .c0_tx_vc_sel_o(tx_vc_sel), .c0_tx_mdata_o(tx_mdata),
        .c0_tx_addr_is_virtual_o(tx_va), .c0_tx_alm_full_i(alm_full),
        .c0_rx_rsp_valid_i(rx_valid), .c0_rx_resp_type_i(rx_type), .c0_rx_data_i(rx_data),
        .buf_wr_en_o(wr_en), .buf_wr_data_o(wr_data), .buf_pop_i(buf_pop),
        .busy_o(busy), .done_o(done), .aborted_o(aborted)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] line_data(input logic [AW-1:0] a);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = {a, 6'(i), 16'h5a5a};
        return d;
    endfunction

    // Reference plan: queues of expected bursts and of expected buffer writes
    logic [AW-1:0] exp_req_addr[$];
    int            exp_req_len[$];
    logic [AW-1:0] pend_q[$];
    logic [511:0]  exp_wr_data[$];
    int            exp_wr_cyc[$];

    int cyc = 0;
    int req_lines_total = 0, req_lines_run = 0;
    int wr_total = 0, wr_run = 0, last_wr_cyc = 0;
    int popped_total = 0, popped_vis = 0;
    int last_req_cyc = -1, thr_cur = 0;
    bit alm_force = 1'b0;
    int alm_pct = 0, pop_pct = 100, resp_pct = 100;
    int pop_budget = -1, resp_budget = -1;
    int busy_cyc = 0, done_cyc = 0;

    int            mon_l, mon_el, mon_c;
    logic [AW-1:0] mon_ea, mon_a;
    logic [511:0]  mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void build_model(input logic [AW-1:0] base, input int num);
        logic [AW-1:0] a = base;
        int rem = num;
        int l;
        while (rem > 0) begin
            if ((a % 4) == 0 && rem >= 4)      l = 4;
            else if ((a % 2) == 0 && rem >= 2) l = 2;
            else                               l = 1;
            exp_req_addr.push_back(a);
            exp_req_len.push_back(l);
            a   = a + AW'(l);
            rem = rem - l;
        end
    endfunction

    // Monitor, in-order memory responder, buffer consumer and almost-full source
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_valid = 1'b0;
            buf_pop  = 1'b0;
            alm_full = 1'b0;
        end else begin
            if (tx_valid) begin
                mon_l = int'(tx_cl_len) + 1;
                check("req_almfull", alm_full, 0);
                if (last_req_cyc >= 0) check("req_gap", (cyc - last_req_cyc) >= thr_cur + 1, 1);
                last_req_cyc = cyc;
                check("req_type", tx_req_type, 0);
                check("req_vc", tx_vc_sel, 0);
                check("req_va_mdata", {tx_va, tx_mdata}, {1'b1, 16'h0});
                if (exp_req_addr.size() == 0) begin
                    check("req_unexpected", tx_addr, 0 - 1);
                end else begin
                    mon_ea = exp_req_addr.pop_front();
                    mon_el = exp_req_len.pop_front();
                    check("req_addr", tx_addr, mon_ea);
                    check("req_len", mon_l, mon_el);
                end
                req_lines_total += mon_l;
                req_lines_run   += mon_l;
                check("credit", (req_lines_total - popped_vis) <= BUF_DEPTH, 1);
                for (int i = 0; i < mon_l; i++) pend_q.push_back(tx_addr + AW'(i));
            end
            if (wr_en) begin
                if (exp_wr_data.size() == 0) begin
                    check("wr_unexpected", wr_en, 0);
                end else begin
                    mon_d = exp_wr_data.pop_front();
                    mon_c = exp_wr_cyc.pop_front();
                    check("wr_data", wr_data, mon_d);
                    check("wr_latency", cyc, mon_c + 1);
                end
                wr_total++;
                wr_run++;
                last_wr_cyc = cyc;
            end
            popped_vis = popped_total;
            buf_pop = 1'b0;
            if (wr_total > popped_total && pop_budget != 0 && $urandom_range(99) < pop_pct) begin
                buf_pop = 1'b1;
                popped_total++;
                if (pop_budget > 0) pop_budget--;
            end
            rx_valid = 1'b0;
            rx_type  = 4'h0;
            if (pend_q.size() > 0 && resp_budget != 0 && $urandom_range(99) < resp_pct) begin
                mon_a    = pend_q.pop_front();
                rx_valid = 1'b1;
                rx_data  = line_data(mon_a);
                exp_wr_data.push_back(rx_data);
                exp_wr_cyc.push_back(cyc);
                if (resp_budget > 0) resp_budget--;
            end else if ($urandom_range(99) < 10) begin
                rx_valid = 1'b1;
                rx_type  = 4'h1;
                rx_data  = {16{$urandom}};
            end
            alm_full = alm_force || ($urandom_range(99) < alm_pct);
        end
    end

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [AW-1:0] b, input int n, input int t);
        build_model(b, n);
        thr_cur       = t;
        last_req_cyc  = -1;
        req_lines_run = 0;
        wr_run        = 0;
        nedge();
        base_addr = b;
        num_lines = LEN_W'(n);
        throttle  = 8'(t);
        start     = 1'b1;
        nedge();
        start     = 1'b0;
        busy_cyc  = cyc;
        check("busy_rise", {busy, done, aborted}, 3'b100);
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            nedge();
            if (done === 1'b1) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        check("done_timeout", seen, 1);
    endtask

    task automatic wait_until_lines(input int target, input bit use_wr, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            nedge();
            seen = use_wr ? (wr_run >= target) : (req_lines_run >= target);
        end
        check("wait_lines_timeout", seen, 1);
    endtask

    task automatic drain_buffer();
        bit seen = 1'b0;
        pop_budget = -1;
        pop_pct    = 100;
        for (int i = 0; i < 200 && !seen; i++) begin
            nedge();
            seen = (popped_total == wr_total) && (pend_q.size() == 0);
        end
        check("drain_timeout", seen, 1);
    endtask

    task automatic end_normal(input int n);
        check("all_req_issued", exp_req_addr.size(), 0);
        check("wr_count", wr_run, n);
        check("req_lines", req_lines_run, n);
        check("end_flags", {busy, aborted}, 2'b00);
        if (n > 0) check("done_after_last_wr", done_cyc, last_wr_cyc + 1);
        else       check("done_zero_len", done_cyc, busy_cyc + 1);
    endtask

    task automatic run_normal(input logic [AW-1:0] b, input int n, input int t);
        begin_run(b, n, t);
        wait_done(3000);
        end_normal(n);
    endtask

    task automatic pulse_abort();
        nedge();
        abort = 1'b1;
        nedge();
        abort = 1'b0;
    endtask

    int r0;

    initial begin
        #1;
        check("reset_outputs", {tx_valid, wr_en, busy, done, aborted}, 5'b0);
        repeat (3) nedge();
        rst_n = 1'b1;
        nedge();

        // Aligned run and unaligned run
        run_normal(AW'('h100), 10, 0);
        run_normal(AW'('h101), 7, 0);
        // Address wrap across the top of the address space
        run_normal({AW{1'b1}} - AW'(1), 6, 0);
        // Zero-length run
        run_normal(AW'('h180), 0, 0);

        // Start while busy is ignored
        begin_run(AW'('h1c0), 40, 1);
        repeat (3) nedge();
        base_addr = AW'('h777);
        num_lines = LEN_W'(3);
        throttle  = 8'd5;
        start     = 1'b1;
        nedge();
        start = 1'b0;
        check("busy_hold", busy, 1);
        wait_done(3000);
        end_normal(40);

        // Credit limit with no consumer, then exactly four pops
        drain_buffer();
        pop_budget = 0;
        resp_pct   = 100;
        begin_run(AW'('h200), 32, 0);
        repeat (40) nedge();
        check("credit_stall_req", req_lines_run, 8);
        check("credit_stall_wr", wr_run, 8);
        pop_budget = 4;
        repeat (40) nedge();
        check("credit_resume_req", req_lines_run, 12);
        pulse_abort();
        pop_budget = -1;
        wait_done(500);
        check("credit_abort_flags", {done, aborted, busy}, 3'b110);
        exp_req_addr.delete();
        exp_req_len.delete();

        // Almost-full window with throttle 3
        drain_buffer();
        begin_run(AW'('h300), 40, 3);
        repeat (6) nedge();
        alm_force = 1'b1;
        nedge();
        r0 = req_lines_run;
        repeat (20) nedge();
        alm_force = 1'b0;
        nedge();
        check("almfull_no_req", req_lines_run, r0);
        wait_done(3000);
        end_normal(40);

        // Abort after two bursts of four with three responses returned
        drain_buffer();
        pop_budget  = 0;
        resp_budget = 0;
        begin_run(AW'('h400), 16, 0);
        wait_until_lines(8, 1'b0, 100);
        repeat (5) nedge();
        check("abort_pre_req", req_lines_run, 8);
        resp_budget = 3;
        wait_until_lines(3, 1'b1, 100);
        pulse_abort();
        resp_budget = -1;
        wait_done(500);
        check("abort_req_lines", req_lines_run, 8);
        check("abort_wr_lines", wr_run, 8);
        check("abort_flags", {done, aborted, busy}, 3'b110);
        exp_req_addr.delete();
        exp_req_len.delete();
        drain_buffer();

        // Randomised runs
        for (int r = 0; r < 14; r++) begin
            alm_pct  = $urandom_range(30);
            pop_pct  = $urandom_range(100, 30);
            resp_pct = $urandom_range(100, 30);
            run_normal(AW'({$urandom, $urandom}), $urandom_range(40), $urandom_range(3));
        end
        alm_pct  = 0;
        pop_pct  = 100;
        resp_pct = 100;

        // Asynchronous reset in the middle of a run
        begin_run(AW'('h600), 40, 0);
        repeat (5) nedge();
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {tx_valid, wr_en, busy, done, aborted}, 5'b0);
        pend_q.delete();
        exp_req_addr.delete();
        exp_req_len.delete();
        exp_wr_data.delete();
        exp_wr_cyc.delete();
        req_lines_total = 0;
        wr_total        = 0;
        popped_total    = 0;
        popped_vis      = 0;
        repeat (3) nedge();
        rst_n = 1'b1;
        nedge();
        check("post_reset_idle", {busy, done, aborted}, 3'b000);
        run_normal(AW'('h700), 9, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
